// File: rtl/snake_ctrl_pkg.sv
// snake_ctrl_pkg: shared constants, direction encodings and FSM states for the snake game sequencer
//   GRID_W/GRID_H    playfield size, outermost rows/columns are walls
//   MAX_SEG/INIT_LEN tail capacity of `move` and live length after reset/restart
//   START_X/START_Y  head position after `move` is reset
//   DIR_*            one-hot direction codes consumed by `move`
//   state_t          sequencer FSM states
package snake_ctrl_pkg;
   localparam int GRID_W   = 100;
   localparam int GRID_H   = 48;
   localparam int MAX_SEG  = 15;
   localparam int INIT_LEN = 3;
   localparam int START_X  = 50;
   localparam int START_Y  = 24;
   localparam logic [4:0] DIR_RIGHT = 5'b00001;
   localparam logic [4:0] DIR_DOWN  = 5'b00010;
   localparam logic [4:0] DIR_LEFT  = 5'b00100;
   localparam logic [4:0] DIR_UP    = 5'b01000;
   localparam logic [4:0] DIR_STOP  = 5'b10000;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_CHECK = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } state_t;
   // swapping the two arrow pairs maps right<->left and down<->up
   function automatic logic [4:0] dir_reverse(input logic [4:0] d);
      return {1'b0, d[1:0], d[3:2]};
   endfunction
endpackage

// File: rtl/snake_ctrl_if.sv
// snake_ctrl_if: signal bundle between the game sequencer and its environment (`move`, keypad, food generator)
//   key              one-hot key pulses into the sequencer
//   head_*, tail_*   snake position registers from `move`
//   food_*           current food cell
//   direction        one-hot direction to `move`
//   move_rst         restart pulse to `move`
//   eat/game_over    game events
//   score/length     game counters
//   state            sequencer FSM state for debug
//   master drives the inputs and observes outputs; slave is the sequencer side
interface snake_ctrl_if;
   logic [4:0]   key;
   logic [6:0]   head_x;
   logic [5:0]   head_y;
   logic [104:0] tail_x;
   logic [89:0]  tail_y;
   logic [6:0]   food_x;
   logic [5:0]   food_y;
   logic [4:0]   direction;
   logic         move_rst;
   logic         eat;
   logic         game_over;
   logic [7:0]   score;
   logic [3:0]   length;
   logic [2:0]   state;
   modport master (
      output key, head_x, head_y, tail_x, tail_y, food_x, food_y,
      input  direction, move_rst, eat, game_over, score, length, state
   );
   modport slave (
      input  key, head_x, head_y, tail_x, tail_y, food_x, food_y,
      output direction, move_rst, eat, game_over, score, length, state
   );
endinterface

// File: rtl/snake_ctrl_dir_filter.sv
// snake_ctrl_dir_filter: decodes a key vector and proposes the next run direction
//   key       raw key vector, valid only when exactly one bit is set
//   cur_dir   direction currently driven to `move`
//   last_dir  direction of the most recent head step
//   nxt_dir   accepted arrow, or cur_dir when the key is invalid, not an arrow, or reverses last_dir
//   arrow     a valid arrow key is present
//   start     a valid start/pause key is present
module snake_ctrl_dir_filter
   import snake_ctrl_pkg::*;
(
   input  logic [4:0] key,
   input  logic [4:0] cur_dir,
   input  logic [4:0] last_dir,
   output logic [4:0] nxt_dir,
   output logic       arrow,
   output logic       start
);
   logic onehot;
   always_comb begin
      onehot  = (key != 5'd0) && ((key & (key - 5'd1)) == 5'd0);
      arrow   = onehot && !key[4];
      start   = onehot && key[4];
      // reversal is judged against the last step taken, not the pending turn
      nxt_dir = (arrow && key != dir_reverse(last_dir)) ? key : cur_dir;
   end
endmodule

// File: rtl/snake_ctrl.sv
// snake_ctrl: game sequencer turning keys into directions and checking every head step for walls, food and self-hits
//   clk, reset  system clock and synchronous active-high reset
//   bus         snake_ctrl_if slave: key, head/tail/food in; direction, move_rst, eat, game_over, score, length, state out
module snake_ctrl #(
   parameter int GRID_W   = snake_ctrl_pkg::GRID_W,
   parameter int GRID_H   = snake_ctrl_pkg::GRID_H,
   parameter int MAX_SEG  = snake_ctrl_pkg::MAX_SEG,
   parameter int INIT_LEN = snake_ctrl_pkg::INIT_LEN,
   parameter int START_X  = snake_ctrl_pkg::START_X,
   parameter int START_Y  = snake_ctrl_pkg::START_Y
) (
   input logic         clk,
   input logic         reset,
   snake_ctrl_if.slave bus
);
   import snake_ctrl_pkg::*;
   state_t     state, nxt_state;
   logic [4:0] cur_dir, last_dir, filt_dir, direction;
   logic [6:0] hp_x;
   logic [5:0] hp_y;
   logic [3:0] idx, length, seg;
   logic [7:0] score;
   logic       arrow, start, step, wall_now, food_now, hit_now, last_cmp, collide, restart, eat_now;
   logic       wall_f, food_f, self_f, move_rst, eat, game_over;

   snake_ctrl_dir_filter u_filter (
      .key      (bus.key),
      .cur_dir  (cur_dir),
      .last_dir (last_dir),
      .nxt_dir  (filt_dir),
      .arrow    (arrow),
      .start    (start)
   );

   // head_prev holds the head under test during CHECK, so all compares use it
   assign step     = (state == S_RUN) && (bus.head_x != hp_x || bus.head_y != hp_y);
   assign wall_now = hp_x == 7'd0 || hp_x >= 7'(GRID_W - 1) || hp_y == 6'd0 || hp_y >= 6'(GRID_H - 1);
   assign food_now = hp_x == bus.food_x && hp_y == bus.food_y;
   // idx 0 is the wall/food cycle; clamping keeps the tail select in range there
   assign seg      = (idx == 4'd0) ? 4'd0 : idx - 4'd1;
   assign hit_now  = idx != 4'd0 && hp_x == bus.tail_x[7*seg +: 7] && hp_y == bus.tail_y[6*seg +: 6];
   assign last_cmp = (state == S_CHECK) && (idx == length);
   // the final tail compare is folded in directly so the exit needs no extra cycle
   assign collide  = wall_f | self_f | hit_now;
   assign eat_now  = last_cmp && food_f && !collide;
   assign restart  = (state == S_OVER) && start;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         S_IDLE:  nxt_state = arrow ? S_RUN : S_IDLE;
         S_RUN:   nxt_state = step ? S_CHECK : (start ? S_PAUSE : S_RUN);
         S_CHECK: nxt_state = last_cmp ? (collide ? S_OVER : S_RUN) : S_CHECK;
         S_PAUSE: nxt_state = start ? S_RUN : S_PAUSE;
         S_OVER:  nxt_state = start ? S_IDLE : S_OVER;
         default: nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      direction = (state == S_RUN || state == S_CHECK) ? cur_dir : DIR_STOP;
      game_over = state == S_OVER;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_dir  <= DIR_RIGHT;
         last_dir <= DIR_RIGHT;
         hp_x     <= 7'(START_X);
         hp_y     <= 6'(START_Y);
         idx      <= 4'd0;
         score    <= 8'd0;
         length   <= 4'(INIT_LEN);
         wall_f   <= 1'b0;
         food_f   <= 1'b0;
         self_f   <= 1'b0;
         move_rst <= 1'b1;
         eat      <= 1'b0;
      end else begin
         move_rst <= restart;
         eat      <= eat_now;
         if (state == S_IDLE && arrow) cur_dir <= bus.key;
         else if (state == S_RUN && !step) cur_dir <= filt_dir;
         // keys arriving on the step cycle are dropped so last_dir and cur_dir never end up reversed
         if (step) begin
            hp_x     <= bus.head_x;
            hp_y     <= bus.head_y;
            last_dir <= cur_dir;
            idx      <= 4'd0;
            wall_f   <= 1'b0;
            food_f   <= 1'b0;
            self_f   <= 1'b0;
         end else if (state == S_CHECK) begin
            idx <= idx + 4'd1;
            if (idx == 4'd0) begin
               wall_f <= wall_now;
               food_f <= food_now;
            end
            if (hit_now) self_f <= 1'b1;
            if (eat_now) begin
               score  <= (score == 8'hff) ? score : score + 8'd1;
               length <= (length == 4'(MAX_SEG)) ? length : length + 4'd1;
            end
         end
         // the head jumping back to start after a restart must not look like a step
         if (restart) begin
            score    <= 8'd0;
            length   <= 4'(INIT_LEN);
            hp_x     <= 7'(START_X);
            hp_y     <= 6'(START_Y);
            last_dir <= DIR_RIGHT;
         end
      end
   end

   assign bus.direction = direction;
   assign bus.move_rst  = move_rst;
   assign bus.eat       = eat;
   assign bus.game_over = game_over;
   assign bus.score     = score;
   assign bus.length    = length;
   assign bus.state     = state;
endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: randomized self-checking bench for snake_ctrl against a step-level game model
module tb_snake_ctrl;
   import snake_ctrl_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [14:0][6:0] tx;
   logic [14:0][5:0] ty;
   int n_checks = 0;
   int n_fail = 0;
   int m_score, m_len;
   logic [4:0] m_cur, m_last;
   logic [6:0] m_hx;
   logic [5:0] m_hy;

   snake_ctrl_if sif();
   assign sif.tail_x = tx;
   assign sif.tail_y = ty;

   snake_ctrl dut (.clk(clk), .reset(reset), .bus(sif));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] opposite(input logic [4:0] d);
      if (d == DIR_RIGHT) return DIR_LEFT;
      if (d == DIR_LEFT) return DIR_RIGHT;
      if (d == DIR_UP) return DIR_DOWN;
      if (d == DIR_DOWN) return DIR_UP;
      return 5'd0;
   endfunction

   task automatic far_tail;
      for (int i = 0; i < 15; i++) begin
         tx[i] = 7'(10 + i);
         ty[i] = 6'd10;
      end
   endtask

   task automatic press(input logic [4:0] k);
      sif.key = k;
      tick;
      sif.key = 5'd0;
   endtask

   task automatic set_head(input logic [6:0] x, input logic [5:0] y);
      sif.head_x = x;
      sif.head_y = y;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      sif.key = 5'd0;
      set_head(7'd50, 6'd24);
      sif.food_x = 7'd90;
      sif.food_y = 6'd40;
      far_tail;
      tick;
      tick;
      if (sif.state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", sif.state, S_IDLE); end n_checks++;
      if (sif.direction !== DIR_STOP) begin n_fail++; $display("FAIL reset_dir: got %b want %b", sif.direction, DIR_STOP); end n_checks++;
      if (sif.move_rst !== 1'b1) begin n_fail++; $display("FAIL reset_move_rst: got %b want 1", sif.move_rst); end n_checks++;
      if (sif.eat !== 1'b0 || sif.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got eat=%b go=%b want 0 0", sif.eat, sif.game_over); end n_checks++;
      if (sif.score !== 8'd0 || sif.length !== 4'd3) begin n_fail++; $display("FAIL reset_counts: got score=%0d len=%0d want 0 3", sif.score, sif.length); end n_checks++;
      reset = 1'b0;
      tick;
      if (sif.move_rst !== 1'b0) begin n_fail++; $display("FAIL reset_move_rst_drop: got %b want 0", sif.move_rst); end n_checks++;
      m_score = 0;
      m_len = 3;
      m_cur = DIR_RIGHT;
      m_last = DIR_RIGHT;
      m_hx = 7'd50;
      m_hy = 6'd24;
   endtask

   task automatic begin_run(input logic [4:0] k);
      press(k);
      m_cur = k;
      if (sif.state !== 3'(S_RUN)) begin n_fail++; $display("FAIL run_state: got %0d want %0d", sif.state, S_RUN); end n_checks++;
      if (sif.direction !== k) begin n_fail++; $display("FAIL run_dir: got %b want %b", sif.direction, k); end n_checks++;
   endtask

   task automatic run_key(input logic [4:0] k);
      press(k);
      if ($countones(k) == 1 && !k[4] && k != opposite(m_last)) m_cur = k;
      if (sif.state !== 3'(S_RUN)) begin n_fail++; $display("FAIL key_state: key=%b got %0d want %0d", k, sif.state, S_RUN); end n_checks++;
      if (sif.direction !== m_cur) begin n_fail++; $display("FAIL key_dir: key=%b got %b want %b", k, sif.direction, m_cur); end n_checks++;
   endtask

   task automatic step_to(input logic [6:0] x, input logic [5:0] y);
      logic wall, food, self_hit, over, dir_ok;
      int n;
      wall = x == 7'd0 || x >= 7'd99 || y == 6'd0 || y >= 6'd47;
      food = x == sif.food_x && y == sif.food_y;
      self_hit = 1'b0;
      for (int i = 0; i < m_len; i++) if (tx[i] == x && ty[i] == y) self_hit = 1'b1;
      over = wall | self_hit;
      set_head(x, y);
      m_hx = x;
      m_hy = y;
      tick;
      n = 0;
      dir_ok = 1'b1;
      while (sif.state === 3'(S_CHECK) && n < 40) begin
         if (sif.direction !== m_cur) dir_ok = 1'b0;
         n++;
         tick;
      end
      m_last = m_cur;
      if (n != m_len + 1) begin n_fail++; $display("FAIL check_cycles: (%0d,%0d) got %0d want %0d", x, y, n, m_len + 1); end n_checks++;
      if (!dir_ok) begin n_fail++; $display("FAIL check_dir: direction left %b during CHECK", m_cur); end n_checks++;
      if (sif.state !== (over ? 3'(S_OVER) : 3'(S_RUN))) begin n_fail++; $display("FAIL check_exit: (%0d,%0d) got %0d want %0d", x, y, sif.state, over ? S_OVER : S_RUN); end n_checks++;
      if (sif.eat !== (food && !over)) begin n_fail++; $display("FAIL check_eat: (%0d,%0d) got %b want %b", x, y, sif.eat, food && !over); end n_checks++;
      if (food && !over) begin
         m_score = m_score < 255 ? m_score + 1 : 255;
         m_len = m_len < 15 ? m_len + 1 : 15;
      end
      if (sif.score !== 8'(m_score) || sif.length !== 4'(m_len)) begin n_fail++; $display("FAIL check_counts: got score=%0d len=%0d want %0d %0d", sif.score, sif.length, m_score, m_len); end n_checks++;
      if (over) begin
         if (sif.game_over !== 1'b1 || sif.direction !== DIR_STOP) begin n_fail++; $display("FAIL over_outputs: got go=%b dir=%b want 1 %b", sif.game_over, sif.direction, DIR_STOP); end n_checks++;
      end
      tick;
      if (sif.eat !== 1'b0) begin n_fail++; $display("FAIL eat_pulse: got %b want 0 one cycle later", sif.eat); end n_checks++;
   endtask

   task automatic restart;
      set_head(7'd50, 6'd24);
      press(DIR_STOP);
      if (sif.state !== 3'(S_IDLE) || sif.move_rst !== 1'b1) begin n_fail++; $display("FAIL restart: got state=%0d mrst=%b want %0d 1", sif.state, sif.move_rst, S_IDLE); end n_checks++;
      if (sif.score !== 8'd0 || sif.length !== 4'd3 || sif.game_over !== 1'b0) begin n_fail++; $display("FAIL restart_counts: got score=%0d len=%0d go=%b want 0 3 0", sif.score, sif.length, sif.game_over); end n_checks++;
      tick;
      if (sif.move_rst !== 1'b0 || sif.state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL restart_pulse: got mrst=%b state=%0d want 0 %0d", sif.move_rst, sif.state, S_IDLE); end n_checks++;
      m_score = 0;
      m_len = 3;
      m_last = DIR_RIGHT;
      m_hx = 7'd50;
      m_hy = 6'd24;
   endtask

   task automatic test_idle_start;
      press(DIR_STOP);
      if (sif.state !== 3'(S_IDLE) || sif.direction !== DIR_STOP) begin n_fail++; $display("FAIL idle_start_ignored: got state=%0d dir=%b", sif.state, sif.direction); end n_checks++;
      begin_run(DIR_RIGHT);
   endtask

   task automatic test_step_basic;
      step_to(7'd51, 6'd24);
   endtask

   task automatic test_keys;
      run_key(DIR_LEFT);
      run_key(DIR_UP);
      run_key(DIR_LEFT);
      run_key(5'b00011);
      run_key(5'b00000);
      run_key(DIR_RIGHT);
   endtask

   task automatic test_food;
      sif.food_x = 7'd52;
      sif.food_y = 6'd24;
      step_to(7'd52, 6'd24);
      step_to(7'd53, 6'd24);
   endtask

   task automatic test_pause;
      press(DIR_STOP);
      if (sif.state !== 3'(S_PAUSE) || sif.direction !== DIR_STOP) begin n_fail++; $display("FAIL pause_enter: got state=%0d dir=%b", sif.state, sif.direction); end n_checks++;
      press(DIR_UP);
      if (sif.state !== 3'(S_PAUSE) || sif.direction !== DIR_STOP) begin n_fail++; $display("FAIL pause_arrow: got state=%0d dir=%b", sif.state, sif.direction); end n_checks++;
      press(DIR_STOP);
      if (sif.state !== 3'(S_RUN) || sif.direction !== m_cur) begin n_fail++; $display("FAIL pause_exit: got state=%0d dir=%b want %0d %b", sif.state, sif.direction, S_RUN, m_cur); end n_checks++;
   endtask

   task automatic test_self_hit;
      tx[2] = 7'd60;
      ty[2] = 6'd30;
      step_to(7'd60, 6'd30);
      restart;
      begin_run(DIR_RIGHT);
   endtask

   task automatic test_wall_with_food;
      sif.food_x = 7'd99;
      sif.food_y = 6'd24;
      step_to(7'd99, 6'd24);
      restart;
      begin_run(DIR_RIGHT);
   endtask

   task automatic test_unused_segment;
      tx[3] = 7'd70;
      ty[3] = 6'd20;
      step_to(7'd70, 6'd20);
   endtask

   task automatic test_random;
      logic [6:0] x;
      logic [5:0] y;
      int r, j;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 15; i++) begin
            tx[i] = 7'($urandom_range(1, 98));
            ty[i] = 6'($urandom_range(1, 46));
         end
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            x = $urandom_range(0, 1) != 0 ? 7'd0 : 7'd99;
            y = 6'($urandom_range(1, 46));
         end else if (r == 1) begin
            x = 7'($urandom_range(1, 98));
            y = $urandom_range(0, 1) != 0 ? 6'd0 : 6'd47;
         end else if (r <= 4) begin
            j = int'($urandom_range(0, 14));
            x = tx[j];
            y = ty[j];
         end else begin
            x = 7'($urandom_range(1, 98));
            y = 6'($urandom_range(1, 46));
         end
         if (x == m_hx && y == m_hy) y = (y == 6'd24) ? 6'd25 : 6'd24;
         if ($urandom_range(0, 2) == 0) begin
            sif.food_x = x;
            sif.food_y = y;
         end else begin
            sif.food_x = 7'($urandom_range(1, 98));
            sif.food_y = 6'($urandom_range(1, 46));
         end
         run_key(5'($urandom_range(0, 15)));
         step_to(x, y);
         if (sif.state === 3'(S_OVER)) begin
            restart;
            begin_run(5'(1 << $urandom_range(0, 3)));
         end
      end
   endtask

   task automatic test_reset_mid_check;
      far_tail;
      sif.food_x = (m_hx == 7'd40) ? 7'd41 : 7'd40;
      sif.food_y = 6'd20;
      step_to(sif.food_x, 6'd20);
      set_head(7'd30, 6'd30);
      tick;
      tick;
      if (sif.state !== 3'(S_CHECK)) begin n_fail++; $display("FAIL midcheck_entry: got %0d want %0d", sif.state, S_CHECK); end n_checks++;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      set_head(7'd50, 6'd24);
      if (sif.state !== 3'(S_IDLE) || sif.move_rst !== 1'b1 || sif.direction !== DIR_STOP) begin n_fail++; $display("FAIL midcheck_reset: got state=%0d mrst=%b dir=%b", sif.state, sif.move_rst, sif.direction); end n_checks++;
      if (sif.score !== 8'd0 || sif.length !== 4'd3) begin n_fail++; $display("FAIL midcheck_counts: got score=%0d len=%0d want 0 3", sif.score, sif.length); end n_checks++;
      tick;
      if (sif.move_rst !== 1'b0) begin n_fail++; $display("FAIL midcheck_mrst_drop: got %b want 0", sif.move_rst); end n_checks++;
   endtask

   initial begin
      test_reset;
      test_idle_start;
      test_step_basic;
      test_keys;
      test_food;
      test_pause;
      test_self_hit;
      test_wall_with_food;
      test_unused_segment;
      test_random;
      test_reset_mid_check;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
